mem_port_arbiter: RTL

Sequential arbiter that shares one single-port unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw, driven by the controller's MemRead/MemWrite). It serialises the two requesters with data priority and drives a pipeline-wide `stall` until both stages are served. It honours the controller's `clr` (as `if_flush`) by cancelling or discarding fetches on the wrong path. It sits between the pipeline registers and the memory model, replacing separate instruction and data memories.

---
 rtl/mips_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 24 ++
 rtl/mem_port_slot.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - arbiter state encoding and bus width defaults shared with the datapath
package mips_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;  // nothing outstanding
    localparam arb_state_t ST_DATA = 2'd1;  // lw/sw request held on the port
    localparam arb_state_t ST_INST = 2'd2;  // fetch request held on the port
    localparam arb_state_t ST_KILL = 2'd3;  // wrong-path fetch draining, result dropped

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - single-port memory request/response bus
// Ports: mem_req/mem_we/mem_addr/mem_wdata are the held request (master drives),
//        mem_rdy/mem_rdata are the completion strobe and read data (slave drives).
interface mem_port_arbiter_if #(
    parameter int AW = mips_pkg::AW_DEF,
    parameter int DW = mips_pkg::DW_DEF
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdy, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdy, mem_rdata
    );
endinterface

// File: rtl/mem_port_slot.sv
// rtl/mem_port_slot.sv - per-requester served flag and captured read data
// Ports: capture (access completed), discard (drop this completion entirely),
//        keep_data (mark served but leave rdata, used for stores),
//        advance (pipeline moves on, served flag clears), cap_data, srv, rdata.
module mem_port_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic          discard,
    input  logic          keep_data,
    input  logic          advance,
    input  logic [DW-1:0] cap_data,
    output logic          srv,
    output logic [DW-1:0] rdata
);
    logic          srv_d, srv_q;
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
        srv_d   = srv_q;
        rdata_d = rdata_q;
        if (capture && !discard) begin
            srv_d = 1'b1;
            if (!keep_data) begin
                rdata_d = cap_data;
            end
        end
        // Captured data is held across the advance; only the flag is per-instruction.
        if (advance) begin
            srv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            srv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            srv_q   <= srv_d;
            rdata_q <= rdata_d;
        end
    end

    assign srv   = srv_q;
    assign rdata = rdata_q;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and MEM with data priority
// Ports: clk, rst (async active-low); IF side if_req/if_addr/if_flush -> if_rdata/if_ok;
//        MEM side d_rd/d_wr/d_addr/d_wdata -> d_rdata/d_ok; stall freezes the pipeline;
//        mem is the registered request bus toward the memory model.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic [DW-1:0] if_rdata,
    output logic          if_ok,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ok,
    output logic          stall,
    mem_port_arbiter_if.master mem
);
    arb_state_t    state_d, state_q;
    logic          req_d, req_q;
    logic          we_d, we_q;
    logic [AW-1:0] addr_d, addr_q;
    logic [DW-1:0] wdata_d, wdata_q;
    logic          d_srv, i_srv;
    logic          d_cap, i_cap;
    logic          d_acc;

    assign d_acc = d_rd | d_wr;
    assign d_ok  = ~d_acc | d_srv;
    assign if_ok = ~if_req | i_srv | if_flush;
    assign stall = ~(d_ok & if_ok);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        d_cap   = 1'b0;
        i_cap   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Data is issued even under flush: a flushing branch in EX must not
                // block the older load/store sitting in MEM.
                if (d_acc && !d_srv) begin
                    state_d = ST_DATA;
                    req_d   = 1'b1;
                    we_d    = d_wr;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                end else if (if_req && !i_srv && !if_flush) begin
                    state_d = ST_INST;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                end
            end
            ST_DATA: begin
                if (mem.mem_rdy) begin
                    d_cap   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_INST: begin
                // A flush coinciding with completion is handled by the slot's discard.
                if (mem.mem_rdy) begin
                    i_cap   = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (if_flush) begin
                    state_d = ST_KILL;
                end
            end
            ST_KILL: begin
                // The memory cannot be cancelled; wait it out and drop the result.
                if (mem.mem_rdy) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    mem_port_slot #(.DW(DW)) u_d_slot (
        .clk       (clk),
        .rst       (rst),
        .capture   (d_cap),
        .discard   (1'b0),
        .keep_data (we_q),
        .advance   (~stall),
        .cap_data  (mem.mem_rdata),
        .srv       (d_srv),
        .rdata     (d_rdata)
    );

    mem_port_slot #(.DW(DW)) u_i_slot (
        .clk       (clk),
        .rst       (rst),
        .capture   (i_cap),
        .discard   (if_flush),
        .keep_data (1'b0),
        .advance   (~stall),
        .cap_data  (mem.mem_rdata),
        .srv       (i_srv),
        .rdata     (if_rdata)
    );
endmodule
